// File: rtl/adc_spi_reader.sv
// ---------------------------------------------------------------------------
// adc_spi_reader
//
// Acquisition front end for the converter control loop. Each trigger starts
// one SPI frame that reads three serial ADCs in parallel (shared chip-select
// and SCLK, one data line per ADC). The last DATA_BITS bits of each frame are
// latched into Vdc1/Vdc2/Iref together, and data_valid pulses for one cycle,
// so downstream logic always sees one coherent sample set per period.
//
// Ports
//   clk          system clock
//   rst          asynchronous reset, active low
//   trigger      start-of-conversion pulse
//   adc_sdata_*  serial data from the Vdc1 / Vdc2 / Iref ADCs
//   clr_overrun  clears the sticky overrun flag
//   adc_cs_n     shared chip-select (active low)
//   adc_sclk     shared serial clock, idles high
//   Vdc1/Vdc2/Iref latest samples (unsigned, DATA_BITS wide)
//   data_valid   one-cycle pulse when the samples update
//   busy         frame or post-frame quiet time in progress
//   overrun      sticky: a trigger arrived while busy
//
// Parameter assumptions: SCLK_DIV >= 1, N_BITS >= 1, DATA_BITS <= N_BITS.
// ---------------------------------------------------------------------------
module adc_spi_reader #(
    parameter int SCLK_DIV     = 2,
    parameter int N_BITS       = 16,
    parameter int DATA_BITS    = 12,
    parameter int QUIET_CYCLES = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 trigger,
    input  logic                 adc_sdata_v1,
    input  logic                 adc_sdata_v2,
    input  logic                 adc_sdata_i,
    input  logic                 clr_overrun,
    output logic                 adc_cs_n,
    output logic                 adc_sclk,
    output logic [DATA_BITS-1:0] Vdc1,
    output logic [DATA_BITS-1:0] Vdc2,
    output logic [DATA_BITS-1:0] Iref,
    output logic                 data_valid,
    output logic                 busy,
    output logic                 overrun
);

    localparam int DIV_W   = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int HALF_W  = (N_BITS > 1) ? $clog2(2 * N_BITS) : 1;
    localparam int QUIET_W = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;

    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(SCLK_DIV - 1);
    // Half-period index of the final SCLK-high hold after the last rising edge.
    localparam logic [HALF_W-1:0]  HALF_LAST  = HALF_W'(2 * N_BITS - 1);
    localparam logic [QUIET_W-1:0] QUIET_LAST = QUIET_W'((QUIET_CYCLES > 0) ? QUIET_CYCLES - 1 : 0);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_QUIET = 3'd4;

    logic [2:0]         state_reg,     state_next;
    logic [DIV_W-1:0]   div_cnt_reg,   div_cnt_next;
    logic [HALF_W-1:0]  half_cnt_reg,  half_cnt_next;
    logic [QUIET_W-1:0] quiet_cnt_reg, quiet_cnt_next;
    logic               cs_n_reg,      cs_n_next;
    logic               sclk_reg,      sclk_next;
    logic               busy_reg,      busy_next;
    logic               valid_reg,     valid_next;
    logic               overrun_reg,   overrun_next;
    logic               shift_en;
    logic               load_en;

    logic [2:0]                  sdata;
    logic [2:0][DATA_BITS-1:0]   sample_bus;

    // Data lines are sampled directly: the ADC output is launched from
    // adc_sclk, which this block generates, so it is source-synchronous.
    assign sdata = {adc_sdata_i, adc_sdata_v2, adc_sdata_v1};

    always_comb begin
        state_next     = state_reg;
        div_cnt_next   = div_cnt_reg;
        half_cnt_next  = half_cnt_reg;
        quiet_cnt_next = quiet_cnt_reg;
        cs_n_next      = cs_n_reg;
        sclk_next      = sclk_reg;
        busy_next      = busy_reg;
        valid_next     = 1'b0;
        shift_en       = 1'b0;
        load_en        = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (trigger) begin
                    state_next   = S_SETUP;
                    cs_n_next    = 1'b0;
                    busy_next    = 1'b1;
                    div_cnt_next = '0;
                end
            end
            S_SETUP: begin
                // CS-to-first-SCLK setup time, SCLK held high.
                if (div_cnt_reg == DIV_LAST) begin
                    div_cnt_next  = '0;
                    half_cnt_next = '0;
                    sclk_next     = 1'b0;
                    state_next    = S_SHIFT;
                end else begin
                    div_cnt_next = div_cnt_reg + 1'b1;
                end
            end
            S_SHIFT: begin
                if (div_cnt_reg == DIV_LAST) begin
                    div_cnt_next = '0;
                    if (half_cnt_reg == HALF_LAST) begin
                        // High hold after the last rising edge is over.
                        state_next = S_DONE;
                        cs_n_next  = 1'b1;
                        load_en    = 1'b1;
                        valid_next = 1'b1;
                    end else begin
                        sclk_next     = ~sclk_reg;
                        // Capture on the edge that drives SCLK 0->1.
                        shift_en      = ~sclk_reg;
                        half_cnt_next = half_cnt_reg + 1'b1;
                    end
                end else begin
                    div_cnt_next = div_cnt_reg + 1'b1;
                end
            end
            S_DONE: begin
                quiet_cnt_next = '0;
                if (QUIET_CYCLES == 0) begin
                    state_next = S_IDLE;
                    busy_next  = 1'b0;
                end else begin
                    state_next = S_QUIET;
                end
            end
            S_QUIET: begin
                if (quiet_cnt_reg == QUIET_LAST) begin
                    state_next = S_IDLE;
                    busy_next  = 1'b0;
                end else begin
                    quiet_cnt_next = quiet_cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
                cs_n_next  = 1'b1;
                sclk_next  = 1'b1;
                busy_next  = 1'b0;
            end
        endcase
    end

    // Set has priority over clear so a coincident overrun is never lost.
    always_comb begin
        overrun_next = overrun_reg;
        if (clr_overrun) begin
            overrun_next = 1'b0;
        end
        if (trigger && busy_reg) begin
            overrun_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= S_IDLE;
            div_cnt_reg   <= '0;
            half_cnt_reg  <= '0;
            quiet_cnt_reg <= '0;
            cs_n_reg      <= 1'b1;
            sclk_reg      <= 1'b1;
            busy_reg      <= 1'b0;
            valid_reg     <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            div_cnt_reg   <= div_cnt_next;
            half_cnt_reg  <= half_cnt_next;
            quiet_cnt_reg <= quiet_cnt_next;
            cs_n_reg      <= cs_n_next;
            sclk_reg      <= sclk_next;
            busy_reg      <= busy_next;
            valid_reg     <= valid_next;
            overrun_reg   <= overrun_next;
        end
    end

    // One shift register and one output register per ADC channel.
    // Index 0 = Vdc1, 1 = Vdc2, 2 = Iref.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            logic [N_BITS-1:0]    shift_reg;
            logic [DATA_BITS-1:0] sample_reg;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    shift_reg  <= '0;
                    sample_reg <= '0;
                end else begin
                    if (shift_en) begin
                        shift_reg <= (shift_reg << 1) | N_BITS'(sdata[gi]);
                    end
                    // Leading N_BITS-DATA_BITS bits are dropped here.
                    if (load_en) begin
                        sample_reg <= shift_reg[DATA_BITS-1:0];
                    end
                end
            end

            assign sample_bus[gi] = sample_reg;
        end
    endgenerate

    assign adc_cs_n   = cs_n_reg;
    assign adc_sclk   = sclk_reg;
    assign busy       = busy_reg;
    assign data_valid = valid_reg;
    assign overrun    = overrun_reg;
    assign Vdc1       = sample_bus[0];
    assign Vdc2       = sample_bus[1];
    assign Iref       = sample_bus[2];

endmodule

// File: tb/tb_adc_spi_reader.sv
// ---------------------------------------------------------------------------
// tb_adc_spi_reader
//
// Two instances: dut (default parameters) and dut_s (SCLK_DIV=1, N_BITS=14).
// Each has a small ADC model that presents the next frame bit, MSB first, on
// every falling adc_sclk edge while adc_cs_n is low. Expected samples are
// pushed into a per-instance queue when a frame is started; a monitor
// process pops and compares whenever data_valid is seen.
// ---------------------------------------------------------------------------
module tb_adc_spi_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic trig;
    logic clr;
    logic sel;      // 0 selects dut, 1 selects dut_s for trigger/clr/observation

    // ---------------- default instance ----------------
    logic        trigger1, clr1;
    logic        sd1_v1, sd1_v2, sd1_i;
    logic        cs1, sclk1, dv1, busy1, ovr1;
    logic [11:0] v1_1, v2_1, i_1;
    logic [15:0] w1_v1, w1_v2, w1_i;
    int          nfall1;

    // ---------------- small instance ----------------
    logic        trigger2, clr2;
    logic        sd2_v1, sd2_v2, sd2_i;
    logic        cs2, sclk2, dv2, busy2, ovr2;
    logic [11:0] v1_2, v2_2, i_2;
    logic [13:0] w2_v1, w2_v2, w2_i;
    int          nfall2;

    assign trigger1 = trig & ~sel;
    assign trigger2 = trig & sel;
    assign clr1     = clr & ~sel;
    assign clr2     = clr & sel;

    logic cs_m, sclk_m, dv_m, busy_m;
    assign cs_m   = sel ? cs2   : cs1;
    assign sclk_m = sel ? sclk2 : sclk1;
    assign dv_m   = sel ? dv2   : dv1;
    assign busy_m = sel ? busy2 : busy1;

    adc_spi_reader dut (
        .clk          (clk),
        .rst          (rst),
        .trigger      (trigger1),
        .adc_sdata_v1 (sd1_v1),
        .adc_sdata_v2 (sd1_v2),
        .adc_sdata_i  (sd1_i),
        .clr_overrun  (clr1),
        .adc_cs_n     (cs1),
        .adc_sclk     (sclk1),
        .Vdc1         (v1_1),
        .Vdc2         (v2_1),
        .Iref         (i_1),
        .data_valid   (dv1),
        .busy         (busy1),
        .overrun      (ovr1)
    );

    adc_spi_reader #(
        .SCLK_DIV     (1),
        .N_BITS       (14),
        .DATA_BITS    (12),
        .QUIET_CYCLES (5)
    ) dut_s (
        .clk          (clk),
        .rst          (rst),
        .trigger      (trigger2),
        .adc_sdata_v1 (sd2_v1),
        .adc_sdata_v2 (sd2_v2),
        .adc_sdata_i  (sd2_i),
        .clr_overrun  (clr2),
        .adc_cs_n     (cs2),
        .adc_sclk     (sclk2),
        .Vdc1         (v1_2),
        .Vdc2         (v2_2),
        .Iref         (i_2),
        .data_valid   (dv2),
        .busy         (busy2),
        .overrun      (ovr2)
    );

    // ADC models: next bit on each falling SCLK, count restarts when CS rises.
    initial begin
        nfall1 = 0;
        sd1_v1 = 1'b0; sd1_v2 = 1'b0; sd1_i = 1'b0;
        nfall2 = 0;
        sd2_v1 = 1'b0; sd2_v2 = 1'b0; sd2_i = 1'b0;
    end

    always @(negedge sclk1 or posedge cs1) begin
        if (cs1) begin
            nfall1 <= 0;
        end else begin
            if (nfall1 < 16) begin
                sd1_v1 <= w1_v1[15 - nfall1];
                sd1_v2 <= w1_v2[15 - nfall1];
                sd1_i  <= w1_i[15 - nfall1];
            end
            nfall1 <= nfall1 + 1;
        end
    end

    always @(negedge sclk2 or posedge cs2) begin
        if (cs2) begin
            nfall2 <= 0;
        end else begin
            if (nfall2 < 14) begin
                sd2_v1 <= w2_v1[13 - nfall2];
                sd2_v2 <= w2_v2[13 - nfall2];
                sd2_i  <= w2_i[13 - nfall2];
            end
            nfall2 <= nfall2 + 1;
        end
    end

    // ---------------- scoreboard ----------------
    int n_pass;
    int n_checks;
    logic [35:0] q1[$];
    logic [35:0] q2[$];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endfunction

    task automatic monitor();
        logic [35:0] e;
        forever begin
            @(negedge clk);
            if (rst && dv1) begin
                check("dut_dv_expected", 32'(q1.size() != 0), 1);
                if (q1.size() != 0) begin
                    e = q1.pop_front();
                    check("dut_Vdc1", v1_1, e[35:24]);
                    check("dut_Vdc2", v2_1, e[23:12]);
                    check("dut_Iref", i_1,  e[11:0]);
                    $display("dut  sample Vdc1=%03h Vdc2=%03h Iref=%03h", v1_1, v2_1, i_1);
                end
            end
            if (rst && dv2) begin
                check("dut_s_dv_expected", 32'(q2.size() != 0), 1);
                if (q2.size() != 0) begin
                    e = q2.pop_front();
                    check("dut_s_Vdc1", v1_2, e[35:24]);
                    check("dut_s_Vdc2", v2_2, e[23:12]);
                    check("dut_s_Iref", i_2,  e[11:0]);
                    $display("dut_s sample Vdc1=%03h Vdc2=%03h Iref=%03h", v1_2, v2_2, i_2);
                end
            end
        end
    endtask

    // Starts a frame at the current negedge (trigger sampled at "edge 0"),
    // then observes one cycle per negedge until busy drops. x1/x2 are extra
    // trigger edges and xc the clr_overrun edge, all relative to edge 0.
    task automatic run_frame(
        input logic        s,
        input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
        input logic [11:0] ea, input logic [11:0] eb, input logic [11:0] ec,
        input int x1, input int x2, input int xc,
        input int exp_cs, input int exp_rise, input int exp_dv_at, input int exp_busy
    );
        int   cs_low, rises, dv_at, dv_cnt, busy_len;
        logic done, prev_sclk;
        sel = s;
        if (!s) begin
            w1_v1 = a; w1_v2 = b; w1_i = c;
            q1.push_back({ea, eb, ec});
        end else begin
            w2_v1 = a[13:0]; w2_v2 = b[13:0]; w2_i = c[13:0];
            q2.push_back({ea, eb, ec});
        end
        trig = 1'b1;
        cs_low = 0; rises = 0; dv_at = 0; dv_cnt = 0; busy_len = 0;
        done = 1'b0;
        prev_sclk = sclk_m;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            if (!cs_m) cs_low++;
            if (sclk_m && !prev_sclk) rises++;
            prev_sclk = sclk_m;
            if (dv_m) begin
                dv_cnt++;
                if (dv_at == 0) dv_at = cyc;
            end
            trig = (cyc == x1) || (cyc == x2);
            clr  = (cyc == xc);
            if (!busy_m) begin
                busy_len = cyc - 1;
                done = 1'b1;
                break;
            end
        end
        trig = 1'b0;
        clr  = 1'b0;
        check("frame_finished", 32'(done), 1);
        check("cs_low_cycles", cs_low, exp_cs);
        check("sclk_rising_edges", rises, exp_rise);
        check("data_valid_cycle", dv_at, exp_dv_at);
        check("data_valid_pulses", dv_cnt, 1);
        check("busy_cycles", busy_len, exp_busy);
        $display("frame sel=%0d data=%04h/%04h/%04h cs_low=%0d rises=%0d dv_at=%0d busy=%0d",
                 s, a, b, c, cs_low, rises, dv_at, busy_len);
    endtask

    initial begin
        logic [31:0] r1, r2;
        n_pass = 0;
        n_checks = 0;
        rst = 1'b0; trig = 1'b0; clr = 1'b0; sel = 1'b0;
        w1_v1 = '0; w1_v2 = '0; w1_i = '0;
        w2_v1 = '0; w2_v2 = '0; w2_i = '0;
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        check("rst_cs_n", cs1, 1);
        check("rst_sclk", sclk1, 1);
        check("rst_Vdc1", v1_1, 0);
        check("rst_Vdc2", v2_1, 0);
        check("rst_Iref", i_1, 0);
        check("rst_data_valid", dv1, 0);
        check("rst_busy", busy1, 0);
        check("rst_overrun", ovr1, 0);
        $display("reset state checked");
        rst = 1'b1;
        @(negedge clk);

        // Basic frame and leading-bit discard.
        run_frame(0, 16'h0ABC, 16'h0123, 16'h0FFF, 12'hABC, 12'h123, 12'hFFF,
                  0, 0, 0, 66, 16, 67, 72);
        run_frame(0, 16'hF555, 16'hF555, 16'hF555, 12'h555, 12'h555, 12'h555,
                  0, 0, 0, 66, 16, 67, 72);
        check("overrun_clear_after_normal", ovr1, 0);

        // Triggers 10 cycles in and in the last quiet cycle are both dropped.
        run_frame(0, 16'h0A5A, 16'h05A5, 16'h7C3C, 12'hA5A, 12'h5A5, 12'hC3C,
                  10, 72, 0, 66, 16, 67, 72);
        check("overrun_set", ovr1, 1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("overrun_cleared", ovr1, 0);
        $display("overrun cleared");

        // clr_overrun coincident with an overrun trigger: set wins.
        run_frame(0, 16'h1234, 16'h8765, 16'h4321, 12'h234, 12'h765, 12'h321,
                  20, 0, 20, 66, 16, 67, 72);
        check("overrun_set_beats_clear", ovr1, 1);

        // Reset in the middle of a frame (SCLK low at that moment).
        sel = 1'b0;
        w1_v1 = 16'h0FED; w1_v2 = 16'h0321; w1_i = 16'h0000;
        trig = 1'b1;
        repeat (31) begin
            @(negedge clk);
            trig = 1'b0;
        end
        check("midframe_cs_low", cs1, 0);
        rst = 1'b0;
        #1;
        check("abort_cs_n", cs1, 1);
        check("abort_sclk", sclk1, 1);
        check("abort_Vdc1", v1_1, 0);
        check("abort_Vdc2", v2_1, 0);
        check("abort_Iref", i_1, 0);
        check("abort_busy", busy1, 0);
        check("abort_data_valid", dv1, 0);
        check("abort_overrun", ovr1, 0);
        $display("mid-frame reset checked");
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("post_abort_idle_cs", cs1, 1);
        check("post_abort_idle_busy", busy1, 0);
        run_frame(0, 16'h0FED, 16'h0321, 16'h0000, 12'hFED, 12'h321, 12'h000,
                  0, 0, 0, 66, 16, 67, 72);

        // Fast-SCLK, 14-bit-frame instance.
        run_frame(1, 16'h2ABC, 16'h1555, 16'h3001, 12'hABC, 12'h555, 12'h001,
                  0, 0, 0, 29, 14, 30, 35);
        check("dut_s_overrun", ovr2, 0);

        // 100 frames, each triggered on the first cycle after busy drops.
        for (int k = 0; k < 100; k++) begin
            r1 = $urandom;
            r2 = $urandom;
            run_frame(0, r1[15:0], r1[31:16], r2[15:0], r1[11:0], r1[27:16], r2[11:0],
                      0, 0, 0, 66, 16, 67, 72);
            check("b2b_no_overrun", ovr1, 0);
        end

        repeat (5) @(negedge clk);
        check("dut_queue_drained", q1.size(), 0);
        check("dut_s_queue_drained", q2.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
